// File: rtl/mem_stage_ext.sv
// LEGv8 MEM stage: branch resolve, sized little-endian loads/stores into a
// byte-addressed data memory with configurable wait states and registered MEM/WB.
module mem_stage_ext #(
  parameter int unsigned WORD    = 64,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic            im_clk,
  input  logic            im_rst_n,
  input  logic            in_valid,
  input  logic            uncondbranch,
  input  logic            branch,
  input  logic            cbnz,
  input  logic            zero,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_size,
  input  logic            load_signed,
  input  logic [WORD-1:0] pc_in,
  input  logic [WORD-1:0] alu_result,
  input  logic [WORD-1:0] read_data2,
  input  logic            mem_to_reg_in,
  input  logic            reg_write_in,
  output logic            stall,
  output logic            pc_src,
  output logic [WORD-1:0] pc_out,
  output logic [WORD-1:0] alu_result_out,
  output logic [WORD-1:0] read_data,
  output logic            mem_to_reg_out,
  output logic            reg_write_out,
  output logic            out_valid,
  output logic            fault
);
  localparam int unsigned BYTES = DEPTH * WORD / 8;
  localparam int unsigned AW    = $clog2(BYTES);
  localparam int unsigned LANES = WORD / 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      mem [BYTES];

  logic [WORD-1:0] pc_q, alu_q, rd_q, rd_d;
  logic            m2r_q, rw_q, valid_q, fault_q;

  logic            is_mem, misalign, oor, illegal, addr_fault, fault_d;
  logic            capture, commit;
  logic [AW-1:0]   addr;
  int unsigned     nbytes, nbits;
  logic [WORD-1:0] raw, mask, topbit, load_ext;

  assign pc_src = in_valid & (uncondbranch | (branch & (zero ^ cbnz)));

  always_comb begin
    is_mem = mem_read | mem_write;
    nbytes = 32'd1 << mem_size;
    unique case (mem_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = alu_result[0];
      2'd2:    misalign = |alu_result[1:0];
      default: misalign = |alu_result[2:0];
    endcase
    oor        = alu_result >= WORD'(BYTES);
    illegal    = (mem_size == 2'd3) && (WORD == 32);
    addr_fault = misalign | oor | illegal;
    fault_d    = is_mem & (addr_fault | (mem_read & mem_write));
  end

  // Gather a full word of bytes, then mask to the access size and sign-extend
  // using the top bit of the mask.
  always_comb begin
    addr = alu_result[AW-1:0];
    raw  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      raw[8*i +: 8] = mem[addr + AW'(i)];
    end
    nbits    = (nbytes * 8 > WORD) ? WORD : nbytes * 8;
    mask     = (nbits == WORD) ? '1 : ((WORD'(1) << nbits) - WORD'(1));
    topbit   = mask & ~(mask >> 1);
    load_ext = raw & mask;
    if (load_signed && |(raw & topbit)) load_ext = load_ext | ~mask;
    rd_d = (mem_read && !fault_d) ? load_ext : '0;
  end

  // stall drops in the final WAIT cycle: the instruction is captured at that
  // edge, so upstream may advance at the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mem && MEM_LAT != 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(MEM_LAT - 1);
            stall   = 1'b1;
          end else begin
            capture = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall = (cnt_q != 4'd0);
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = capture & mem_write & ~addr_fault & im_rst_n;

  always_ff @(posedge im_clk) begin
    if (!im_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= capture;
      if (capture) begin
        pc_q    <= pc_in;
        alu_q   <= alu_result;
        rd_q    <= rd_d;
        m2r_q   <= mem_to_reg_in;
        rw_q    <= reg_write_in & ~fault_d;
        fault_q <= fault_d;
      end
    end
  end

  always_ff @(posedge im_clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (i < nbytes) mem[addr + AW'(i)] <= read_data2[8*i +: 8];
      end
    end
  end

  assign pc_out         = pc_q;
  assign alu_result_out = alu_q;
  assign read_data      = rd_q;
  assign mem_to_reg_out = m2r_q;
  assign reg_write_out  = rw_q;
  assign out_valid      = valid_q;
  assign fault          = fault_q;
endmodule

// File: tb/tb_mem_stage_ext.sv
// Randomized and directed bench for mem_stage_ext against a byte-array memory model.
module tb_mem_stage_ext;
  localparam int unsigned WORD    = 64;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned BYTES   = DEPTH * WORD / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, in_valid, uncondbranch, branch, cbnz, zero;
  logic            mem_read, mem_write, load_signed, mem_to_reg_in, reg_write_in;
  logic [1:0]      mem_size;
  logic [WORD-1:0] pc_in, alu_result, read_data2;
  logic            stall, pc_src, mem_to_reg_out, reg_write_out, out_valid, fault;
  logic [WORD-1:0] pc_out, alu_result_out, read_data;

  mem_stage_ext #(.WORD(WORD), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .im_clk(clk), .im_rst_n(rst_n), .in_valid(in_valid),
    .uncondbranch(uncondbranch), .branch(branch), .cbnz(cbnz), .zero(zero),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .load_signed(load_signed), .pc_in(pc_in), .alu_result(alu_result),
    .read_data2(read_data2), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .stall(stall), .pc_src(pc_src),
    .pc_out(pc_out), .alu_result_out(alu_result_out), .read_data(read_data),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .out_valid(out_valid), .fault(fault)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  ref_mem [BYTES];

  typedef struct {
    int          lat;
    int          stalls;
    logic        early;
    logic        ovn;
    logic        psrc;
    logic [63:0] pc_o, alu_o, rd;
    logic        m2r, rw, flt;
  } res_t;

  // Reference model: memory as a plain byte array, values by arithmetic.
  function automatic logic ref_fault(logic rd, logic wr, logic [1:0] sz, logic [63:0] a);
    longint unsigned n = 64'd1 << sz;
    if (!(rd || wr)) return 1'b0;
    return ((a % n) != 0) || (a >= BYTES) || (rd && wr);
  endfunction

  function automatic logic [63:0] ref_load(logic [1:0] sz, logic sgn, logic [63:0] a);
    int          n = 1 << sz;
    logic [63:0] v = 64'd0;
    for (int i = n - 1; i >= 0; i--) v = (v << 8) | 64'(ref_mem[int'(a[10:0]) + i]);
    if (sgn && n < 8 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    return v;
  endfunction

  task automatic ref_store(logic [1:0] sz, logic [63:0] a, logic [63:0] d);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) ref_mem[int'(a[10:0]) + i] = d[8*i +: 8];
  endtask

  task automatic set_idle();
    in_valid = 0; uncondbranch = 0; branch = 0; cbnz = 0; zero = 0;
    mem_read = 0; mem_write = 0; mem_size = 0; load_signed = 0;
    pc_in = '0; alu_result = '0; read_data2 = '0; mem_to_reg_in = 0; reg_write_in = 0;
  endtask

  // Presents one instruction, holds it while stalled, then waits for out_valid.
  task automatic do_op(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                       input logic sgn, input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] pc, input logic m2r, input logic rw,
                       output res_t r);
    @(negedge clk);
    mem_read = rd_en; mem_write = wr_en; mem_size = sz; load_signed = sgn;
    alu_result = a; read_data2 = wd; pc_in = pc; mem_to_reg_in = m2r;
    reg_write_in = rw; branch = 0; uncondbranch = 0; in_valid = 1;
    r.lat = 0; r.stalls = 0; r.early = 0;
    #1; r.psrc = pc_src;
    while (stall && r.stalls < 20) begin
      r.stalls++;
      @(negedge clk); r.lat++;
      if (out_valid) r.early = 1;
      #1;
    end
    @(negedge clk); r.lat++;
    in_valid = 0; mem_read = 0; mem_write = 0;
    while (!out_valid && r.lat < 30) begin @(negedge clk); r.lat++; end
    r.pc_o = pc_out; r.alu_o = alu_result_out; r.rd = read_data;
    r.m2r = mem_to_reg_out; r.rw = reg_write_out; r.flt = fault;
    @(negedge clk); r.ovn = out_valid;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
    total++; if (pc_out !== 64'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    total++; if (alu_result_out !== 64'd0) begin bad++; $display("FAIL reset_alu got=%h exp=0", alu_result_out); end
    total++; if (read_data !== 64'd0) begin bad++; $display("FAIL reset_rd got=%h exp=0", read_data); end
    total++; if ({mem_to_reg_out, reg_write_out} !== 2'b00) begin bad++; $display("FAIL reset_wb got=%b%b exp=00", mem_to_reg_out, reg_write_out); end
  endtask

  task automatic test_init_mem();
    res_t r;
    logic [63:0] d;
    for (int a = 0; a < 256; a += 8) begin
      d = {$urandom, $urandom};
      do_op(0, 1, 2'd3, 0, 64'(a), d, 64'h100, 0, 0, r);
      ref_store(2'd3, 64'(a), d);
      total++; if (r.lat != 3 || r.flt !== 1'b0) begin bad++; $display("FAIL init_store a=%0d lat=%0d fault=%b exp lat=3 fault=0", a, r.lat, r.flt); end
    end
  endtask

  task automatic test_directed();
    res_t r;
    do_op(0, 1, 2'd3, 0, 64'h10, 64'h1122334455667788, 64'h40, 0, 0, r);
    ref_store(2'd3, 64'h10, 64'h1122334455667788);
    total++; if (r.stalls != 2) begin bad++; $display("FAIL st_stall got=%0d exp=2", r.stalls); end
    do_op(1, 0, 2'd3, 0, 64'h10, 64'd0, 64'h44, 1, 1, r);
    total++; if (r.rd !== 64'h1122334455667788) begin bad++; $display("FAIL ld_dword got=%h exp=1122334455667788", r.rd); end
    total++; if (r.stalls != 2 || r.lat != 3) begin bad++; $display("FAIL ld_timing got stalls=%0d lat=%0d exp 2/3", r.stalls, r.lat); end
    total++; if (r.early !== 1'b0) begin bad++; $display("FAIL ld_early_valid got=%b exp=0", r.early); end
    do_op(0, 1, 2'd0, 0, 64'h13, 64'hF0, 64'h48, 0, 0, r);
    ref_store(2'd0, 64'h13, 64'hF0);
    do_op(1, 0, 2'd0, 1, 64'h13, 64'd0, 64'h4C, 1, 1, r);
    total++; if (r.rd !== 64'hFFFFFFFFFFFFFFF0) begin bad++; $display("FAIL ld_byte_s got=%h exp=fffffffffffffff0", r.rd); end
    do_op(1, 0, 2'd0, 0, 64'h13, 64'd0, 64'h50, 1, 1, r);
    total++; if (r.rd !== 64'hF0) begin bad++; $display("FAIL ld_byte_u got=%h exp=f0", r.rd); end
    do_op(1, 0, 2'd3, 0, 64'h10, 64'd0, 64'h54, 1, 1, r);
    total++; if (r.rd !== 64'h11223344F0667788) begin bad++; $display("FAIL ld_merge got=%h exp=11223344f0667788", r.rd); end
    do_op(1, 0, 2'd1, 0, 64'h11, 64'd0, 64'h58, 1, 1, r);
    total++; if ({r.flt, r.rw} !== 2'b10 || r.rd !== 64'd0) begin bad++; $display("FAIL ld_misalign fault=%b rw=%b rd=%h exp 1/0/0", r.flt, r.rw, r.rd); end
    total++; if (r.lat != 3) begin bad++; $display("FAIL ld_misalign_lat got=%0d exp=3", r.lat); end
    do_op(0, 1, 2'd1, 0, 64'h11, 64'hBEEF, 64'h5C, 0, 0, r);
    do_op(1, 0, 2'd3, 0, 64'h10, 64'd0, 64'h60, 1, 1, r);
    total++; if (r.rd !== 64'h11223344F0667788) begin bad++; $display("FAIL misalign_nowrite got=%h exp=11223344f0667788", r.rd); end
  endtask

  task automatic test_branch();
    logic exp;
    @(negedge clk);
    set_idle();
    in_valid = 1; branch = 1; cbnz = 1; zero = 0; #1;
    total++; if (pc_src !== 1'b1) begin bad++; $display("FAIL br_cbnz got=%b exp=1", pc_src); end
    zero = 1; #1;
    total++; if (pc_src !== 1'b0) begin bad++; $display("FAIL br_cbnz_zero got=%b exp=0", pc_src); end
    uncondbranch = 1; #1;
    total++; if (pc_src !== 1'b1) begin bad++; $display("FAIL br_uncond got=%b exp=1", pc_src); end
    in_valid = 0; #1;
    total++; if (pc_src !== 1'b0) begin bad++; $display("FAIL br_invalid got=%b exp=0", pc_src); end
    for (int i = 0; i < 32; i++) begin
      {in_valid, uncondbranch, branch, cbnz, zero} = 5'(i); #1;
      if (!in_valid) exp = 0;
      else if (uncondbranch) exp = 1;
      else if (branch) exp = cbnz ? !zero : zero;
      else exp = 0;
      total++; if (pc_src !== exp) begin bad++; $display("FAIL br_combo i=%0d got=%b exp=%b", i, pc_src, exp); end
    end
    set_idle();
  endtask

  task automatic test_random();
    res_t r;
    int kind, am, n;
    logic [1:0] sz;
    logic sgn, m2r, rw, rd_en, wr_en, ef, erw;
    logic [63:0] a, wd, pc, erd;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3)); n = 1 << sz;
      sgn = 1'($urandom); m2r = 1'($urandom); rw = 1'($urandom);
      wd = {$urandom, $urandom}; pc = {$urandom, $urandom};
      am = $urandom_range(0, 9);
      if (am < 7) a = 64'(($urandom_range(0, 255) / n) * n);
      else if (am < 9) a = 64'($urandom_range(0, 255 - n + 1));
      else a = 64'(BYTES + $urandom_range(0, 255 - 8));
      if (kind == 2) a = {$urandom, $urandom};
      rd_en = (kind == 0); wr_en = (kind == 1);
      ef  = ref_fault(rd_en, wr_en, sz, a);
      erw = rw && !ef;
      erd = (rd_en && !ef) ? ref_load(sz, sgn, a) : 64'd0;
      do_op(rd_en, wr_en, sz, sgn, a, wd, pc, m2r, rw, r);
      if (wr_en && !ef) ref_store(sz, a, wd);
      total++; if (r.flt !== ef) begin bad++; $display("FAIL rnd_fault it=%0d got=%b exp=%b", it, r.flt, ef); end
      total++; if (r.rw !== erw || r.m2r !== m2r) begin bad++; $display("FAIL rnd_wb it=%0d got=%b%b exp=%b%b", it, r.rw, r.m2r, erw, m2r); end
      total++; if (r.pc_o !== pc || r.alu_o !== a) begin bad++; $display("FAIL rnd_pass it=%0d pc=%h alu=%h exp %h %h", it, r.pc_o, r.alu_o, pc, a); end
      total++; if (r.lat != ((kind == 2) ? 1 : 3) || r.stalls != ((kind == 2) ? 0 : 2)) begin bad++; $display("FAIL rnd_timing it=%0d lat=%0d stalls=%0d kind=%0d", it, r.lat, r.stalls, kind); end
      total++; if (r.early !== 1'b0 || r.ovn !== 1'b0) begin bad++; $display("FAIL rnd_valid_pulse it=%0d early=%b next=%b exp 0/0", it, r.early, r.ovn); end
      if (rd_en) begin
        total++; if (r.rd !== erd) begin bad++; $display("FAIL rnd_load it=%0d a=%h sz=%0d s=%b got=%h exp=%h", it, a, sz, sgn, r.rd, erd); end
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t r1, r2;
    do_op(1, 0, 2'd2, 1, 64'h40, 64'd0, 64'h1, 1, 1, r1);
    do_op(1, 0, 2'd2, 0, 64'h44, 64'd0, 64'h2, 1, 1, r2);
    total++; if (r1.rd !== ref_load(2'd2, 1, 64'h40) || r2.rd !== ref_load(2'd2, 0, 64'h44)) begin bad++; $display("FAIL b2b_data got=%h %h", r1.rd, r2.rd); end
    total++; if (r2.lat != 3 || r2.pc_o !== 64'h2) begin bad++; $display("FAIL b2b_second lat=%0d pc=%h exp 3/2", r2.lat, r2.pc_o); end
  endtask

  task automatic test_reset_mid();
    res_t r;
    logic [63:0] prior;
    prior = ref_load(2'd3, 0, 64'h20);
    @(negedge clk);
    set_idle();
    mem_write = 1; mem_size = 2'd3; alu_result = 64'h20; read_data2 = ~prior; in_valid = 1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rm_stall_pre got=%b exp=1", stall); end
    @(negedge clk);
    rst_n = 0; set_idle();
    @(negedge clk);
    total++; if (stall !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rm_after stall=%b valid=%b exp 0/0", stall, out_valid); end
    rst_n = 1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_no_capture got=%b exp=0", out_valid); end
    do_op(1, 0, 2'd3, 0, 64'h20, 64'd0, 64'h3, 1, 1, r);
    total++; if (r.rd !== prior) begin bad++; $display("FAIL rm_nowrite got=%h exp=%h", r.rd, prior); end
  endtask

  initial begin
    test_reset();
    test_init_mem();
    test_directed();
    test_branch();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
